// File: rtl/id_select_pipe.sv
// Decode/select stage of the 3-stage MIPS32 pipeline: IR latch, one-hot register selects,
// EX-aligned ALU control and WB-aligned destination. Define HAZARD_STALL_EN for the RAW interlock.
module id_select_pipe #(
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ibus,
    input  logic        stall_in,
    output logic [31:0] Aselect,
    output logic [31:0] Bselect,
    output logic [31:0] Dselect,
    output logic [31:0] Imm,
    output logic        ImmSel,
    output logic [2:0]  S,
    output logic        Cin,
    output logic        hazard
);

    logic [31:0] ir_q, ir_d;
    logic [2:0]  s_q, s_d;
    logic        cin_q, cin_d;
    logic        immSel_q, immSel_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] dselEx_q, dselEx_d;
    logic [31:0] dselWb_q, dselWb_d;

    logic [5:0]  op, funct, aluCode;
    logic [4:0]  rs, rt, rd;
    logic        isImm, known, stall;
    logic [2:0]  decS;
    logic        decCin, decImmSel;
    logic [31:0] decDest, decImm;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];

    assign Aselect = 32'h1 << rs;
    assign decImm  = {{16{ir_q[15]}}, ir_q[15:0]};

    // I-type opcodes are folded onto the equivalent R-type funct so one table drives the ALU.
    always_comb begin
        Bselect   = 32'h1;
        aluCode   = funct;
        isImm     = 1'b0;
        known     = 1'b1;
        decS      = 3'b000;
        decCin    = 1'b0;
        decImmSel = 1'b0;
        decDest   = 32'h1;
        if (op == 6'b000000) begin
            Bselect = 32'h1 << rt;
        end else begin
            isImm = 1'b1;
            case (op)
                6'b000011, 6'b000010, 6'b000001: aluCode = op;
                6'b001111:                       aluCode = 6'b000111;
                6'b001100:                       aluCode = 6'b000100;
                default:                         aluCode = 6'b111111;
            endcase
        end
        case (aluCode)
            6'b000011: decS = 3'b010;
            6'b000010: begin
                decS   = 3'b011;
                decCin = 1'b1;
            end
            6'b000001: decS = 3'b000;
            6'b000111: decS = 3'b110;
            6'b000100: decS = 3'b100;
            default:   known = 1'b0;
        endcase
        if (known) begin
            decImmSel = isImm;
            decDest   = isImm ? (32'h1 << rt) : (32'h1 << rd);
        end
    end

`ifdef HAZARD_STALL_EN
    // Bselect is the R0 select for I-types, so it never contributes once bit 0 is masked off.
    logic [31:0] srcMask;
    assign srcMask = Aselect | Bselect;
    assign hazard  = |(srcMask & (dselEx_q | dselWb_q) & ~32'h1);
`else
    assign hazard = 1'b0;
`endif

    assign stall = stall_in | hazard;

    always_comb begin
        ir_d     = stall ? ir_q : ibus;
        dselWb_d = dselEx_q;
        if (stall) begin
            s_d      = 3'b000;
            cin_d    = 1'b0;
            immSel_d = 1'b0;
            imm_d    = 32'h0;
            dselEx_d = 32'h1;
        end else begin
            s_d      = decS;
            cin_d    = decCin;
            immSel_d = decImmSel;
            imm_d    = decImm;
            dselEx_d = decDest;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q     <= NOP_WORD;
            s_q      <= 3'b000;
            cin_q    <= 1'b0;
            immSel_q <= 1'b0;
            imm_q    <= 32'h0;
            dselEx_q <= 32'h1;
            dselWb_q <= 32'h1;
        end else begin
            ir_q     <= ir_d;
            s_q      <= s_d;
            cin_q    <= cin_d;
            immSel_q <= immSel_d;
            imm_q    <= imm_d;
            dselEx_q <= dselEx_d;
            dselWb_q <= dselWb_d;
        end
    end

    assign S       = s_q;
    assign Cin     = cin_q;
    assign ImmSel  = immSel_q;
    assign Imm     = imm_q;
    assign Dselect = dselWb_q;

endmodule

// File: tb/tb_id_select_pipe.sv
// Scoreboard bench for id_select_pipe: a register-number reference model queues expected outputs,
// a negedge monitor compares them; directed cases from the test plan plus randomized traffic.
module tb_id_select_pipe;

    typedef struct {
        logic [2:0]  s;
        logic        cin;
        logic        immSel;
        logic [31:0] imm;
        logic [31:0] dest;
    } exCtrl_t;

    typedef struct {
        logic [31:0] aSel;
        logic [31:0] bSel;
        logic [31:0] dSel;
        logic [31:0] imm;
        logic [2:0]  s;
        logic        cin;
        logic        immSel;
        logic        haz;
    } expect_t;

    logic        clk;
    logic        reset;
    logic [31:0] ibus;
    logic        stall_in;
    logic [31:0] Aselect, Bselect, Dselect, Imm;
    logic        ImmSel, Cin, hazard;
    logic [2:0]  S;

    int errors = 0;
    int checks = 0;

    expect_t     expQ[$];
    logic [31:0] irM;
    exCtrl_t     exM;
    logic [31:0] wbM;

    id_select_pipe dut (
        .clk     (clk),
        .reset   (reset),
        .ibus    (ibus),
        .stall_in(stall_in),
        .Aselect (Aselect),
        .Bselect (Bselect),
        .Dselect (Dselect),
        .Imm     (Imm),
        .ImmSel  (ImmSel),
        .S       (S),
        .Cin     (Cin),
        .hazard  (hazard)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mkR(input int rs, input int rt, input int rd, input int fn);
        return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
    endfunction

    function automatic logic [31:0] mkI(input int op, input int rs, input int rt, input int imm);
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'hFFFF);
    endfunction

    function automatic exCtrl_t modelDecode(input logic [31:0] instr);
        exCtrl_t     r;
        int          op;
        int          fn;
        int          dstReg;
        logic [2:0]  s;
        logic        cin;
        logic        useImm;
        logic [15:0] low;
        op     = int'(instr[31:26]);
        fn     = int'(instr[5:0]);
        low    = instr[15:0];
        s      = 3'b000;
        cin    = 1'b0;
        useImm = 1'b0;
        if (op == 0) begin
            dstReg = int'(instr[15:11]);
            case (fn)
                3:       s = 3'b010;
                2:       begin s = 3'b011; cin = 1'b1; end
                1:       s = 3'b000;
                7:       s = 3'b110;
                4:       s = 3'b100;
                default: dstReg = -1;
            endcase
        end else begin
            dstReg = int'(instr[20:16]);
            useImm = 1'b1;
            case (op)
                3:       s = 3'b010;
                2:       begin s = 3'b011; cin = 1'b1; end
                1:       s = 3'b000;
                15:      s = 3'b110;
                12:      s = 3'b100;
                default: begin dstReg = -1; useImm = 1'b0; end
            endcase
        end
        r.s      = s;
        r.cin    = cin;
        r.immSel = useImm;
        r.imm    = {{16{low[15]}}, low};
        r.dest   = (dstReg < 0) ? 32'h1 : (32'h1 << dstReg);
        return r;
    endfunction

    function automatic logic modelHazard(input logic [31:0] instr, input logic [31:0] exDest, input logic [31:0] wbDest);
        int   reads[2];
        int   n;
        logic found;
        reads[0] = int'(instr[25:21]);
        reads[1] = int'(instr[20:16]);
        n        = (instr[31:26] == 6'd0) ? 2 : 1;
        found    = 1'b0;
        for (int i = 0; i < n; i++)
            if (reads[i] != 0 && (exDest == (32'h1 << reads[i]) || wbDest == (32'h1 << reads[i])))
                found = 1'b1;
`ifdef HAZARD_STALL_EN
        return found;
`else
        return 1'b0 & found;
`endif
    endfunction

    function automatic exCtrl_t bubble();
        exCtrl_t b;
        b.s = 3'b000; b.cin = 1'b0; b.immSel = 1'b0; b.imm = 32'h0; b.dest = 32'h1;
        return b;
    endfunction

    task automatic resetModel();
        irM = 32'h0;
        exM = bubble();
        wbM = 32'h1;
    endtask

    // Presents one cycle of input, advances the model across the coming edge and queues its outputs.
    task automatic applyStimulus(input logic [31:0] instr, input logic stall, output logic accepted);
        expect_t e;
        logic    stallNow;
        logic    rtypeIr;
        ibus     = instr;
        stall_in = stall;
        stallNow = stall || modelHazard(irM, exM.dest, wbM);
        wbM      = exM.dest;
        exM      = stallNow ? bubble() : modelDecode(irM);
        if (!stallNow) irM = instr;
        rtypeIr  = (irM[31:26] == 6'd0);
        e.aSel   = 32'h1 << irM[25:21];
        e.bSel   = rtypeIr ? (32'h1 << irM[20:16]) : 32'h1;
        e.dSel   = wbM;
        e.imm    = exM.imm;
        e.s      = exM.s;
        e.cin    = exM.cin;
        e.immSel = exM.immSel;
        e.haz    = modelHazard(irM, exM.dest, wbM);
        expQ.push_back(e);
        accepted = !stallNow;
        @(posedge clk);
        #1;
    endtask

    task automatic issueInstr(input logic [31:0] instr);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            applyStimulus(instr, 1'b0, acc);
            tries++;
        end while (!acc && tries < 10);
        if (!acc) checkOutput("issueTimeout", 32'(tries), 32'(0));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".Aselect"}, Aselect, 32'h1);
        checkOutput({tag, ".Bselect"}, Bselect, 32'h1);
        checkOutput({tag, ".Dselect"}, Dselect, 32'h1);
        checkOutput({tag, ".S"}, 32'(S), 32'h0);
        checkOutput({tag, ".Cin"}, 32'(Cin), 32'h0);
        checkOutput({tag, ".Imm"}, Imm, 32'h0);
        checkOutput({tag, ".ImmSel"}, 32'(ImmSel), 32'h0);
        checkOutput({tag, ".hazard"}, 32'(hazard), 32'h0);
    endtask

    function automatic logic [31:0] randInstr();
        int kind;
        int fnList[6];
        int opList[5];
        fnList = '{3, 2, 1, 7, 4, 9};
        opList = '{3, 2, 1, 15, 12};
        kind   = int'($urandom_range(0, 7));
        if (kind <= 2)
            return mkR(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       fnList[$urandom_range(0, 5)]);
        else if (kind <= 5)
            return mkI(opList[$urandom_range(0, 4)], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 65535)));
        else if (kind == 6)
            return $urandom;
        return 32'h0;
    endfunction

    task automatic randomTraffic(input int cycles);
        logic [31:0] cur;
        logic        acc;
        cur = randInstr();
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(cur, ($urandom_range(0, 4) == 0), acc);
            if (acc) cur = randInstr();
        end
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("Aselect", Aselect, e.aSel);
                checkOutput("Bselect", Bselect, e.bSel);
                checkOutput("Dselect", Dselect, e.dSel);
                checkOutput("Imm", Imm, e.imm);
                checkOutput("S", 32'(S), 32'(e.s));
                checkOutput("Cin", 32'(Cin), 32'(e.cin));
                checkOutput("ImmSel", 32'(ImmSel), 32'(e.immSel));
                checkOutput("hazard", 32'(hazard), 32'(e.haz));
            end
        end
    end

    initial begin
        logic acc;
        int   hazCount;
        reset    = 1'b1;
        ibus     = 32'h0;
        stall_in = 1'b0;
        resetModel();
        #2;
        checkReset("por");
        @(negedge clk);
        reset = 1'b0;

        // ADD r3,r1,r2 then SUBI r5,r4,-1 with explicit timing checks
        issueInstr(32'h00221803);
        checkOutput("add.Aselect", Aselect, 32'h2);
        checkOutput("add.Bselect", Bselect, 32'h4);
        applyStimulus(32'h0885FFFF, 1'b0, acc);
        checkOutput("add.S", 32'(S), 32'h2);
        checkOutput("add.Cin", 32'(Cin), 32'h0);
        checkOutput("add.ImmSel", 32'(ImmSel), 32'h0);
        checkOutput("subi.Aselect", Aselect, 32'h10);
        checkOutput("subi.Bselect", Bselect, 32'h1);
        applyStimulus(32'h0, 1'b0, acc);
        checkOutput("add.Dselect", Dselect, 32'h8);
        checkOutput("subi.Imm", Imm, 32'hFFFFFFFF);
        checkOutput("subi.ImmSel", 32'(ImmSel), 32'h1);
        checkOutput("subi.S", 32'(S), 32'h3);
        checkOutput("subi.Cin", 32'(Cin), 32'h1);
        applyStimulus(32'h0, 1'b0, acc);
        checkOutput("subi.Dselect", Dselect, 32'h20);

        // ADD, XOR, OR with a two-cycle external stall while XOR is waiting
        issueInstr(32'h00221803);
        applyStimulus(mkR(4, 5, 6, 1), 1'b1, acc);
        applyStimulus(mkR(4, 5, 6, 1), 1'b1, acc);
        issueInstr(mkR(4, 5, 6, 1));
        issueInstr(mkR(1, 2, 7, 4));
        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, acc);

        // undefined opcode behaves as a NOP
        issueInstr(32'hFC221803);
        applyStimulus(32'h0, 1'b0, acc);
        checkOutput("undef.S", 32'(S), 32'h0);
        checkOutput("undef.ImmSel", 32'(ImmSel), 32'h0);
        applyStimulus(32'h0, 1'b0, acc);
        checkOutput("undef.Dselect", Dselect, 32'h1);
        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, acc);

        // ADDI r1,r0,5 followed by ADD r2,r1,r1
        issueInstr(mkI(3, 0, 1, 5));
        issueInstr(mkR(1, 1, 2, 3));
        hazCount = int'(hazard);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0, 1'b0, acc);
            hazCount += int'(hazard);
        end
`ifdef HAZARD_STALL_EN
        checkOutput("raw.hazardCycles", 32'(hazCount), 32'd2);
`else
        checkOutput("raw.hazardCycles", 32'(hazCount), 32'd0);
`endif
        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, acc);

        randomTraffic(250);

        // asynchronous reset with instructions in flight
        issueInstr(32'h00221803);
        issueInstr(32'h0885FFFF);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkReset("midReset");
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        resetModel();

        randomTraffic(150);
        for (int i = 0; i < 4; i++) applyStimulus(32'h0, 1'b0, acc);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
